fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, program memory address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 12, instruction word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port n_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port load_valid  input  1  boot loader word valid.
REQ-006 SHALL have port load_data  input  INSTR_WIDTH  boot loader instruction word.
REQ-007 SHALL have port load_last  input  1  marks final boot word.
REQ-008 SHALL have port load_ready  output  1  controller accepts boot word.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  program memory read address (= pc).
REQ-010 SHALL have port mem_instr  input  INSTR_WIDTH  combinational read data from program memory.
REQ-011 SHALL have ports mem_we (output, 1), mem_waddr (output, ADDR_WIDTH) and mem_wdata (output, INSTR_WIDTH), the program memory write port.
REQ-012 SHALL have ports stall (input, 1) to hold fetch, and branch_en (input, 1) with branch_target (input, ADDR_WIDTH) to redirect pc.
REQ-013 SHALL have ports halt_req (input, 1) to enter HALT and resume (input, 1) to leave HALT.
REQ-014 SHALL have ports ir (output, INSTR_WIDTH) fetched instruction, ir_pc (output, ADDR_WIDTH) its address, and ir_valid (output, 1).
REQ-015 SHALL have port state_o  output  2  current state encoding (LOAD/RUN/HALT).

Function
REQ-016 SHALL implement states LOAD, RUN, HALT.
REQ-017 In LOAD: load_ready=1; mem_we = load_valid (combinational); mem_waddr = load counter; mem_wdata = load_data.
REQ-018 Accepted word (load_valid & load_ready) SHALL increment the load counter by 1.
REQ-019 Accepted word with load_last=1, or accepted word at counter = 2^ADDR_WIDTH-1, SHALL move to RUN next cycle with pc=0; the counter never wraps.
REQ-020 Outside LOAD: load_ready=0, mem_we=0.
REQ-021 In RUN, when stall=0 and branch_en=0, each cycle SHALL set ir<=mem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0).
REQ-022 In RUN, stall=1 (branch_en=0) SHALL hold pc, ir, ir_pc and ir_valid unchanged.
REQ-023 In RUN, branch_en=1 SHALL take priority over stall: pc<=branch_target, ir_valid<=0 next cycle (flush); the fetch from the target follows one cycle later.
REQ-024 In RUN, halt_req=1 SHALL move to HALT next cycle with ir_valid<=0; if branch_en is also 1, pc<=branch_target, else pc is held (not incremented).
REQ-025 In HALT: pc held, ir_valid=0; all inputs except resume and n_reset ignored.
REQ-026 resume=1 in HALT SHALL return to RUN next cycle; the first fetch is from the held pc.
REQ-027 mem_addr SHALL equal pc combinationally in all states.
REQ-028 Fetch latency: instruction at pc appears on ir one cycle after pc is presented.

Reset
REQ-029 n_reset=0 at a rising edge SHALL set state=LOAD (or RUN, see REQ-032), pc=0, load counter=0, ir=0, ir_pc=0, ir_valid=0, from any state including mid-load.
REQ-030 During reset, load_ready=0 and mem_we=0.

Configuration
REQ-031 Macro FETCH_BOOT_LOAD_EN defined: LOAD state and the boot-load path are present as specified.
REQ-032 Macro absent: no LOAD state; reset enters RUN; load_ready, mem_we, mem_waddr and mem_wdata are tied 0; load inputs are ignored.

Structure
REQ-033 Shared package cpu_pkg SHALL hold the fetch_state_t enum (LOAD=2'd0, RUN=2'd1, HALT=2'd2).
REQ-034 The pc update logic SHALL be one sub-module, pc_next_sel (branch/stall/increment mux), instantiated once.

Verification
REQ-035 Load 3 words (0x111, 0x222, 0x333 with load_last on the third) -> writes to addresses 0,1,2; RUN on the following cycle with pc=0.
REQ-036 Load 16 words with load_last=0 -> after the 16th accept, RUN; no write issued to address 0 a second time.
REQ-037 RUN from pc=15, no stall -> ir_pc=15, then pc=0, ir_pc=0 (wrap).
REQ-038 branch_en=1, target=0x9, stall=1 in the same cycle -> pc=9, ir_valid=0 for one cycle, then ir_pc=9.
REQ-039 halt_req at pc=5, hold 4 cycles, then resume -> ir_valid=0 throughout HALT; the first valid ir_pc after resume is 5.
REQ-040 n_reset=0 after the 2nd load word -> state LOAD, counter=0; reloading writes from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch controller state encoding.
package cpu_pkg;

  localparam int unsigned STATE_W = 2;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-pc selection: clear on boot completion, branch, hold, or increment.
module pc_next_sel #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  i_run,
  input  logic                  i_clear,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_branch_en,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_next
);

  // Branch beats halt and stall; increment wraps naturally at the address width.
  always_comb begin
    o_pc_next = i_pc;
    if (i_clear) begin
      o_pc_next = '0;
    end else if (i_run) begin
      if (i_branch_en) begin
        o_pc_next = i_branch_target;
      end else if (!i_halt && !i_stall) begin
        o_pc_next = ADDR_WIDTH'(i_pc + ADDR_WIDTH'(1));
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller with optional boot loader.
// Macro FETCH_BOOT_LOAD_EN enables the LOAD state and program-memory write
// path; without it reset goes straight to RUN and the load port is inert.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned INSTR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_instr,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_waddr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0]  ir_pc,
  output logic                   ir_valid,
  output logic [1:0]             state_o
);

`ifdef FETCH_BOOT_LOAD_EN
  localparam fetch_state_t RESET_STATE = LOAD;
`else
  localparam fetch_state_t RESET_STATE = RUN;
`endif

  fetch_state_t            r_state;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [INSTR_WIDTH-1:0]  r_ir;
  logic [ADDR_WIDTH-1:0]   r_ir_pc;
  logic                    r_ir_valid;
  logic [ADDR_WIDTH-1:0]   w_pc_next;
  logic                    w_run;
  logic                    w_load_done;

  assign w_run = (r_state == RUN);

`ifdef FETCH_BOOT_LOAD_EN
  localparam logic [ADDR_WIDTH-1:0] LOAD_MAX = '1;

  logic [ADDR_WIDTH-1:0] r_load_cnt;
  logic                  w_in_load;
  logic                  w_load_accept;

  // Loader handshake is suppressed while reset is asserted.
  assign w_in_load     = (r_state == LOAD) && n_reset;
  assign w_load_accept = w_in_load && load_valid;
  assign w_load_done   = w_load_accept && (load_last || (r_load_cnt == LOAD_MAX));

  assign load_ready = w_in_load;
  assign mem_we     = w_load_accept;
  assign mem_waddr  = r_load_cnt;
  assign mem_wdata  = load_data;

  // Load counter: steps per accepted word and saturates at the top address.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_load_cnt <= '0;
    end else if (w_load_accept && (r_load_cnt != LOAD_MAX)) begin
      r_load_cnt <= ADDR_WIDTH'(r_load_cnt + ADDR_WIDTH'(1));
    end
  end
`else
  logic w_unused_load;

  assign w_unused_load = ^{load_valid, load_last, load_data};
  assign w_load_done   = 1'b0;
  assign load_ready    = 1'b0;
  assign mem_we        = 1'b0;
  assign mem_waddr     = '0;
  assign mem_wdata     = '0;
`endif

  pc_next_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_next_sel (
    .i_run           (w_run),
    .i_clear         (w_load_done),
    .i_stall         (stall),
    .i_halt          (halt_req),
    .i_branch_en     (branch_en),
    .i_branch_target (branch_target),
    .i_pc            (r_pc),
    .o_pc_next       (w_pc_next)
  );

  // Control FSM and fetch registers; pc comes from the selector every cycle.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state    <= RESET_STATE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      case (r_state)
        LOAD: begin
          r_ir_valid <= 1'b0;
          if (w_load_done) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (halt_req) begin
            r_state    <= HALT;
            r_ir_valid <= 1'b0;
          end else if (branch_en) begin
            r_ir_valid <= 1'b0;
          end else if (!stall) begin
            r_ir       <= mem_instr;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
          end
        end
        HALT: begin
          r_ir_valid <= 1'b0;
          if (resume) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state    <= RESET_STATE;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = r_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign state_o  = r_state;

endmodule
